// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
//   state_e  : control FSM states
//   pp_sel_e : partial-product select produced by the Booth recoder
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        PP_ZERO = 3'd0,
        PP_POS1 = 3'd1,
        PP_POS2 = 3'd2,
        PP_NEG1 = 3'd3,
        PP_NEG2 = 3'd4
    } pp_sel_e;

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: maps the {Q[1],Q[0],q_m1} window to a partial
// product drawn from {0, +M, +2M, -M, -2M}, sized N+2 bits.
//   win   : 3-bit recode window
//   m_ext : multiplicand already extended to N bits
//   pp    : selected partial product, N+2 bits, two's complement
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int unsigned N = 10
) (
    input  logic [2:0]   win,
    input  logic [N-1:0] m_ext,
    output logic [N+1:0] pp
);

    localparam int unsigned PP_W = N + 2;

    pp_sel_e        sel;
    logic [N+1:0]   m_x1;
    logic [N+1:0]   m_x2;

    assign m_x1 = {m_ext[N-1], m_ext[N-1], m_ext};
    assign m_x2 = {m_ext[N-1], m_ext, 1'b0};

    // Booth window decode
    always_comb begin
        sel = PP_ZERO;
        case (win)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
    end

    // Partial product; negation is invert plus one
    always_comb begin
        pp = '0;
        case (sel)
            PP_POS1: pp = m_x1;
            PP_POS2: pp = m_x2;
            PP_NEG1: pp = ~m_x1 + PP_W'(1);
            PP_NEG2: pp = ~m_x2 + PP_W'(1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier, 2 multiplier bits per clock,
// signed or unsigned per operation, start/ready/done handshake.
//   clk, rst                : clock, async active-high reset
//   start, is_signed        : request and mode, sampled when ready=1
//   multiplicand, multiplier: operands, sampled on accept
//   ready, busy, done       : handshake status (done is a 1-cycle pulse)
//   product                 : 2*WIDTH result, held until the next done
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned N     = WIDTH + 2;
    localparam int unsigned ITER  = (WIDTH + 2) / 2;
    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_chk
        $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
    end

    state_e             state_q, state_d;
    logic [N+1:0]       a_q, a_d;
    logic [N-1:0]       q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [N-1:0]       m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               done_q, ready_q, busy_q;
    logic [N+1:0]       pp;
    logic [N+1:0]       sum;

    booth_r4_recode #(.N(N)) u_recode (
        .win   ({q_q[1:0], qm1_q}),
        .m_ext (m_q),
        .pp    (pp)
    );

    assign sum = a_q + pp;

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Two extra bits make unsigned operands positive in signed Booth
                    m_d     = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                        : {2'b00, multiplicand};
                    q_d     = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                        : {2'b00, multiplier};
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Add, then arithmetic shift right by 2 of {A,Q,q_m1}
                a_d   = {{2{sum[N+1]}}, sum[N+1:2]};
                q_d   = {sum[1:0], q_q[N-1:2]};
                qm1_d = q_q[1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d   = DONE;
                    product_d = PW'({a_d, q_d});
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= (state_d == DONE);
            ready_q   <= (state_d != CALC);
            busy_q    <= (state_d == CALC);
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
module tb_booth_r4_mult_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        s8, sg8;
    logic [7:0]  m8, q8;
    logic        rdy8, bsy8, dn8;
    logic [15:0] p8;

    logic        s16, sg16;
    logic [15:0] m16, q16;
    logic        rdy16, bsy16, dn16;
    logic [31:0] p16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_r4_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .is_signed(sg8),
        .multiplicand(m8), .multiplier(q8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .product(p8)
    );

    booth_r4_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .is_signed(sg16),
        .multiplicand(m16), .multiplier(q16),
        .ready(rdy16), .busy(bsy16), .done(dn16), .product(p16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer product of the operands as interpreted by mode
    function automatic logic [31:0] ref_mul(input bit w16, input logic [15:0] m,
                                            input logic [15:0] q, input bit sgn);
        longint a, b, p;
        logic [15:0] m_w, q_w;
        m_w = w16 ? m : {8'h00, m[7:0]};
        q_w = w16 ? q : {8'h00, q[7:0]};
        if (sgn) begin
            a = w16 ? longint'($signed(m_w)) : longint'($signed(m_w[7:0]));
            b = w16 ? longint'($signed(q_w)) : longint'($signed(q_w[7:0]));
        end else begin
            a = longint'(m_w);
            b = longint'(q_w);
        end
        p = a * b;
        return w16 ? p[31:0] : {16'h0000, p[15:0]};
    endfunction

    // Issue one op (from IDLE or DONE), scramble inputs after accept, wait for done
    task automatic run_op(input bit w16, input logic [15:0] m, input logic [15:0] q,
                          input bit sgn, output logic [31:0] prod, output int lat);
        if (w16) begin s16 = 1'b1; m16 = m; q16 = q; sg16 = sgn; end
        else     begin s8 = 1'b1; m8 = m[7:0]; q8 = q[7:0]; sg8 = sgn; end
        tick();
        s8 = 1'b0; s16 = 1'b0;
        m8 = 8'($urandom); q8 = 8'($urandom); sg8 = 1'($urandom);
        m16 = 16'($urandom); q16 = 16'($urandom); sg16 = 1'($urandom);
        lat = 1;
        while (!(w16 ? dn16 : dn8) && lat < 40) begin
            tick();
            lat++;
        end
        prod = w16 ? p16 : {16'h0000, p8};
    endtask

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        bit          sgn;
        logic [15:0] exp;
        string       tag;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] prod;
        int          lat;
        int          seen;
        logic [15:0] rm, rq;
        bit          rs;

        rst = 1'b1;
        s8 = 1'b0; sg8 = 1'b0; m8 = '0; q8 = '0;
        s16 = 1'b0; sg16 = 1'b0; m16 = '0; q16 = '0;
        tick(); tick();
        check("reset_product", {16'h0, p8}, 32'h0);
        check("reset_status", {29'h0, rdy8, bsy8, dn8}, 32'h4);
        rst = 1'b0;
        tick();

        vecs.push_back('{8'd5,   8'd20,  1'b1, 16'h0064, "s_5x20"});
        vecs.push_back('{8'hCE,  8'd5,   1'b1, 16'hFF06, "s_m50x5"});
        vecs.push_back('{8'hFF,  8'hFF,  1'b0, 16'hFE01, "u_255x255"});
        vecs.push_back('{8'hFF,  8'hFF,  1'b1, 16'h0001, "s_m1xm1"});
        vecs.push_back('{8'h80,  8'h80,  1'b1, 16'h4000, "s_m128xm128"});
        vecs.push_back('{8'h80,  8'h7F,  1'b1, 16'hC080, "s_m128x127"});
        vecs.push_back('{8'h00,  8'hB3,  1'b1, 16'h0000, "s_0xm77"});
        foreach (vecs[i]) begin
            run_op(1'b0, {8'h00, vecs[i].m}, {8'h00, vecs[i].q}, vecs[i].sgn, prod, lat);
            check({vecs[i].tag, "_prod"}, prod, {16'h0, vecs[i].exp});
            check({vecs[i].tag, "_lat"}, 32'(lat), 32'd6);
            tick();
        end

        // Done is a single pulse; product holds afterwards
        check("done_pulse_width", {31'h0, dn8}, 32'h0);
        check("product_hold", {16'h0, p8}, 32'h0);

        // start held through CALC with changing operands: only first op computed
        s8 = 1'b1; m8 = 8'd12; q8 = 8'd12; sg8 = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            m8 = 8'($urandom); q8 = 8'($urandom); sg8 = 1'($urandom);
            check("calc_status", {30'h0, rdy8, bsy8}, 32'h1);
            tick();
        end
        s8 = 1'b0;
        tick();
        check("held_start_done", {31'h0, dn8}, 32'h1);
        check("held_start_prod", {16'h0, p8}, 32'h0090);
        tick();

        // Back-to-back: second start issued in the DONE cycle
        run_op(1'b0, 16'd7, 16'd9, 1'b1, prod, lat);
        check("b2b_first_prod", prod, 32'h003F);
        check("b2b_ready_in_done", {31'h0, rdy8}, 32'h1);
        run_op(1'b0, 16'h00FD, 16'd11, 1'b1, prod, lat);
        check("b2b_spacing", 32'(lat), 32'd6);
        check("b2b_second_prod", prod, 32'hFFDF);
        tick();

        // Reset in cycle 3 of CALC aborts the op
        s8 = 1'b1; m8 = 8'd100; q8 = 8'd100; sg8 = 1'b0;
        tick();
        s8 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_mid_prod", {16'h0, p8}, 32'h0);
        check("rst_mid_status", {29'h0, rdy8, bsy8, dn8}, 32'h4);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (dn8) seen++;
            tick();
        end
        check("rst_no_done", 32'(seen), 32'h0);
        check("rst_ready_after", {31'h0, rdy8}, 32'h1);
        run_op(1'b0, 16'd3, 16'd10, 1'b0, prod, lat);
        check("post_rst_prod", prod, 32'h001E);
        tick();

        // WIDTH=16 random, mixed modes, corners forced periodically
        for (int i = 0; i < 2000; i++) begin
            rm = 16'($urandom); rq = 16'($urandom); rs = 1'($urandom);
            if (i % 97 == 0) begin rm = 16'h8000; rq = 16'h8000; end
            if (i % 89 == 0) begin rm = 16'hFFFF; rq = 16'hFFFF; end
            run_op(1'b1, rm, rq, rs, prod, lat);
            check("w16_rand_prod", prod, ref_mul(1'b1, rm, rq, rs));
            check("w16_rand_lat", 32'(lat), 32'd10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
